// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
// move_scheduler: scans a source board, dispatches one generator per piece of
// the side to move, and packs all successor boards into one contiguous list.
// Revision: 1.0
// ============================================================================
module move_scheduler #(
  parameter int MAX_BOARDS  = 256,
  parameter int BOARD_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic [2:0]  gen_sel,
  output logic [3:0]  gen_address,
  output logic        gen_write,
  output logic [31:0] gen_writedata,
  output logic        gen_read,
  input  logic [31:0] gen_readdata,
  input  logic        gen_waitrequest
);

  localparam logic [31:0] MAX_B  = 32'(MAX_BOARDS);
  localparam logic [31:0] STRIDE = 32'(BOARD_BYTES);

  typedef enum logic [3:0] {
    IDLE, SCAN_RD, SCAN_WAIT, CHECK, GEN_CFG,
    GEN_START, GEN_POLL, ACCUM, NEXT_SQ, DONE
  } state_t;

  state_t      state;
  logic [31:0] src_board_addr;
  logic [31:0] dest_board_addr;
  logic        side;
  logic [5:0]  sq;
  logic [31:0] total;
  logic [7:0]  pc;
  logic [7:0]  cnt;

  logic [7:0]  pc_abs;
  logic        dispatch;
  logic [31:0] dest_cur;
  logic [32:0] sum;
  logic [31:0] total_next;
  logic        hold_read;

  assign pc_abs   = pc[7] ? (~pc + 8'd1) : pc;
  assign dispatch = (pc != 8'd0) && (pc[7] == side) && (pc_abs <= 8'd6) && (total < MAX_B);
  assign dest_cur = dest_board_addr + STRIDE * total;
  assign sum      = {1'b0, total} + {25'd0, cnt};
  assign total_next = (sum > {1'b0, MAX_B}) ? MAX_B : sum[31:0];

  // A busy register-0 read is stalled until the scan has finished; the cycle
  // that enters DONE already releases it so the read completes there.
  assign hold_read = slave_read && (slave_address == 4'd0) &&
                     (state != IDLE) && (state != DONE) &&
                     !((state == NEXT_SQ) && (sq == 6'd63));

  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0:    slave_readdata = total;
      4'd1:    slave_readdata = src_board_addr;
      4'd2:    slave_readdata = dest_board_addr;
      4'd3:    slave_readdata = {31'd0, side};
      default: slave_readdata = 32'd0;
    endcase
  end

  wire unused_bits = &{1'b0, master_readdata[31:8], gen_readdata[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      src_board_addr    <= 32'd0;
      dest_board_addr   <= 32'd0;
      side              <= 1'b0;
      sq                <= 6'd0;
      total             <= 32'd0;
      pc                <= 8'd0;
      cnt               <= 8'd0;
      slave_waitrequest <= 1'b0;
      master_address    <= 32'd0;
      master_read       <= 1'b0;
      gen_sel           <= 3'd0;
      gen_address       <= 4'd0;
      gen_write         <= 1'b0;
      gen_writedata     <= 32'd0;
      gen_read          <= 1'b0;
    end else begin
      slave_waitrequest <= hold_read;
      case (state)
        IDLE: begin
          if (slave_write) begin
            case (slave_address)
              4'd0: begin
                sq             <= 6'd0;
                total          <= 32'd0;
                master_read    <= 1'b1;
                master_address <= src_board_addr;
                state          <= SCAN_RD;
              end
              4'd1:    src_board_addr  <= slave_writedata;
              4'd2:    dest_board_addr <= slave_writedata;
              4'd3:    side            <= slave_writedata[0];
              default: ;
            endcase
          end
        end
        SCAN_RD: begin
          if (!master_waitrequest) begin
            master_read <= 1'b0;
            state       <= SCAN_WAIT;
          end
        end
        SCAN_WAIT: begin
          if (master_readdatavalid) begin
            pc    <= master_readdata[7:0];
            state <= CHECK;
          end
        end
        CHECK: begin
          if (dispatch) begin
            gen_sel       <= pc_abs[2:0];
            gen_write     <= 1'b1;
            gen_address   <= 4'd1;
            gen_writedata <= src_board_addr;
            state         <= GEN_CFG;
          end else begin
            state <= NEXT_SQ;
          end
        end
        GEN_CFG: begin
          // gen_address doubles as the configuration step counter (1..4).
          if (!gen_waitrequest) begin
            case (gen_address)
              4'd1: begin
                gen_address   <= 4'd2;
                gen_writedata <= dest_cur;
              end
              4'd2: begin
                gen_address   <= 4'd3;
                gen_writedata <= {29'd0, sq[2:0]};
              end
              4'd3: begin
                gen_address   <= 4'd4;
                gen_writedata <= {29'd0, sq[5:3]};
              end
              default: begin
                gen_address   <= 4'd0;
                gen_writedata <= 32'd0;
                state         <= GEN_START;
              end
            endcase
          end
        end
        GEN_START: begin
          if (!gen_waitrequest) begin
            gen_write <= 1'b0;
            gen_read  <= 1'b1;
            state     <= GEN_POLL;
          end
        end
        GEN_POLL: begin
          if (!gen_waitrequest) begin
            cnt      <= gen_readdata[7:0];
            gen_read <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          total   <= total_next;
          gen_sel <= 3'd0;
          state   <= NEXT_SQ;
        end
        NEXT_SQ: begin
          if (sq == 6'd63) begin
            state <= DONE;
          end else begin
            sq             <= sq + 6'd1;
            master_read    <= 1'b1;
            master_address <= src_board_addr + {24'd0, sq + 6'd1, 2'b00};
            state          <= SCAN_RD;
          end
        end
        DONE: begin
          if (slave_read && (slave_address == 4'd0) && !slave_waitrequest)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
